envelope_unit: RTL and testbench
================================

Name: envelope_unit

Overview:
- Consumer end of the frame-sequencer clock chain: takes the divided 64 Hz level clock (clock_64) and applies volume-envelope steps to one sound channel.
- Runs entirely in the system clock domain. clock_64 is sampled as data and edge-detected into a one-cycle tick.
- Outputs the current 4-bit channel volume and DAC enable to the channel mixer.

Parameters:
- VOL_W, 4, volume width; max volume = 2^VOL_W-1.
- PER_W, 3, envelope period field width; period 0 = envelope frozen.

Ports:
- clock  input  1  system clock, all logic on posedge
- reset_n  input  1  asynchronous active-low reset
- clock_64  input  1  64 Hz level from the clock divider; sampled, never used as a clock
- trigger  input  1  one-cycle channel (re)start pulse
- init_volume  input  VOL_W  volume loaded on trigger
- env_dir  input  1  1 = increase, 0 = decrease
- env_period  input  PER_W  ticks per envelope step
- volume  output  VOL_W  current channel volume
- env_active  output  1  envelope still stepping
- dac_en  output  1  channel DAC enabled
- tick_64  output  1  one-cycle pulse per clock_64 rising edge (debug/observe)

Behaviour:
- Reset (reset_n low, async): volume=0, env_active=0, tick_64=0, period counter=0, edge/sync flops=0.
  - dac_en follows its combinational definition, so it is 0 while the NR register inputs are 0.
- Edge detect: register clock_64 into c64_q. tick_64 = c64_s & ~c64_q, where c64_s is the sampled value (see Optional Feature).
  - Without sync, tick_64 is high in the cycle after clock_64 is first seen high.
  - Exactly one tick per rising edge; a held-high level produces no further ticks.
- dac_en = (init_volume != 0) | env_dir, combinational.
- Trigger handling (trigger=1):
  - volume <= init_volume.
  - counter <= env_period.
  - env_active <= (env_period != 0).
  - Trigger has priority: a tick in the same cycle is discarded.
- States: IDLE (env_active=0) and STEP (env_active=1).
- STEP behaviour on each tick_64 with no trigger:
  - If counter > 1: counter <= counter-1.
  - If counter == 1: counter <= env_period (re-read live), then apply a volume step:
    - env_dir=1 and volume < max: volume+1.
    - env_dir=0 and volume > 0: volume-1.
    - Otherwise: volume unchanged and env_active <= 0 (go to IDLE).
  - If env_period was changed to 0 at reload: env_active <= 0 and volume is held.
- Saturation: volume never wraps. Stepping up stops at max (15), stepping down stops at 0.
- IDLE ignores ticks; volume is held until the next trigger.
- reset_n asserted mid-step aborts immediately to reset values. No pending step survives reset.
- env_dir and init_volume changes outside a trigger affect only the direction of later steps and dac_en; they never reload volume.

Optional Feature:
- Macro ENVELOPE_SYNC_EN.
- Defined:
  - clock_64 passes through a 2-flop synchronizer before the edge-detect flop; c64_s is the second sync flop.
  - tick_64 latency is 3 clocks after the clock_64 rising edge.
  - Required when the divider runs off an unrelated clock.
- Undefined:
  - c64_s = clock_64 directly; tick_64 latency is 1 clock.
  - clock_64 must then be synchronous to clock.

Test Plan:
- Reset release, all inputs 0, clock_64 toggling -> volume=0, env_active=0, dac_en=0 throughout; tick_64 pulses once per clock_64 rise.
- trigger with init_volume=3, env_dir=1, env_period=2 -> volume steps 3→4 on the 2nd tick, 4→5 on the 4th tick, and so on up to 15; one further reload then drops env_active to 0 and volume stays 15.
- trigger with init_volume=2, env_dir=0, env_period=1 -> volume 2→1→0 on consecutive ticks; the next tick clears env_active; dac_en=1.
- env_period=0, init_volume=9 -> volume stays 9 forever and env_active=0. With init_volume=0, env_dir=0 -> dac_en=0.
- trigger coincident with tick_64 while volume=7 -> volume=init_volume, counter=env_period, no step taken that cycle.
- reset_n pulsed low mid-sequence (volume=12) -> volume=0 and env_active=0 in the same cycle (async). With ENVELOPE_SYNC_EN, tick_64 appears exactly 3 clocks after the clock_64 rise.

Source files
------------

// File: rtl/envelope_unit_if.sv
// rtl/envelope_unit_if.sv - envelope unit channel-side signal bundle.
interface envelope_unit_if #(
  parameter int VOL_W = 4,
  parameter int PER_W = 3
);
  logic             clock_64;
  logic             trigger;
  logic [VOL_W-1:0] init_volume;
  logic             env_dir;
  logic [PER_W-1:0] env_period;
  logic [VOL_W-1:0] volume;
  logic             env_active;
  logic             dac_en;
  logic             tick_64;

  modport master (
    output clock_64, trigger, init_volume, env_dir, env_period,
    input  volume, env_active, dac_en, tick_64
  );

  modport slave (
    input  clock_64, trigger, init_volume, env_dir, env_period,
    output volume, env_active, dac_en, tick_64
  );
endinterface

// File: rtl/envelope_unit.sv
// rtl/envelope_unit.sv - 64 Hz volume envelope stepper for one sound channel.
// Define ENVELOPE_SYNC_EN to pass clock_64 through a 2-flop synchronizer.
module envelope_unit #(
  parameter int VOL_W = 4,
  parameter int PER_W = 3
) (
  input  logic          clock,
  input  logic          reset_n,
  envelope_unit_if.slave env
);
  typedef enum logic {IDLE, STEP} state_e;

  localparam logic [VOL_W-1:0] VOL_MAX = '1;

  state_e           state_q, state_d;
  logic [VOL_W-1:0] vol_q, vol_d;
  logic [PER_W-1:0] cnt_q, cnt_d;
  logic             c64_q, c64_d;
  logic             tick_q, tick_d;
  logic             c64_s;

`ifdef ENVELOPE_SYNC_EN
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;

  always_comb begin
    sync1_d = env.clock_64;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign c64_s = sync2_q;
`else
  assign c64_s = env.clock_64;
`endif

  always_comb begin
    state_d = state_q;
    vol_d   = vol_q;
    cnt_d   = cnt_q;
    c64_d   = c64_s;
    tick_d  = c64_s & ~c64_q;

    // A trigger wins over a tick arriving in the same cycle.
    if (env.trigger) begin
      vol_d   = env.init_volume;
      cnt_d   = env.env_period;
      state_d = (env.env_period != '0) ? STEP : IDLE;
    end else if (tick_q && (state_q == STEP)) begin
      if (cnt_q > PER_W'(1)) begin
        cnt_d = cnt_q - PER_W'(1);
      end else begin
        cnt_d = env.env_period;
        if (env.env_period == '0) begin
          state_d = IDLE;
        end else if (env.env_dir && (vol_q != VOL_MAX)) begin
          vol_d = vol_q + VOL_W'(1);
        end else if (!env.env_dir && (vol_q != '0)) begin
          vol_d = vol_q - VOL_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      vol_q   <= '0;
      cnt_q   <= '0;
      c64_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      vol_q   <= vol_d;
      cnt_q   <= cnt_d;
      c64_q   <= c64_d;
      tick_q  <= tick_d;
    end
  end

  assign env.volume     = vol_q;
  assign env.env_active = (state_q == STEP);
  assign env.tick_64    = tick_q;
  assign env.dac_en     = (env.init_volume != '0) | env.env_dir;
endmodule

// File: tb/tb_envelope_unit.sv
// tb/tb_envelope_unit.sv - scoreboard bench for envelope_unit.
module tb_envelope_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  envelope_unit_if #(.VOL_W(4), .PER_W(3)) bus ();

  envelope_unit #(.VOL_W(4), .PER_W(3)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .env     (bus)
  );

  typedef struct packed {
    logic [3:0] vol;
    logic       act;
    logic       dac;
  } exp_t;

`ifdef ENVELOPE_SYNC_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 1;
`endif

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    passes = 0;
  int    ticks_seen = 0;
  int    pulses_sent = 0;
  int    probe_seq = 0;
  int    mon_probes = 0;

  task automatic check(input string nm, input int got, input int want);
    checks++;
    if (got == want) passes++;
    else $display("FAIL %s: got %0d, required %0d", nm, got, want);
  endtask

  task automatic expect_state(input string nm, input int v, input int a, input int d);
    exp_t e;
    e.vol = 4'(v);
    e.act = 1'(a);
    e.dac = 1'(d);
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic compare_next(input string kind);
    exp_t  e;
    string nm;
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL unexpected_%s: got an output with no expectation queued, required none", kind);
    end else begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      check({nm, ".volume"},     int'(bus.volume),     int'(e.vol));
      check({nm, ".env_active"}, int'(bus.env_active), int'(e.act));
      check({nm, ".dac_en"},     int'(bus.dac_en),     int'(e.dac));
    end
  endtask

  // Monitor: ticks carry the pre-step state, probes carry the settled state.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.tick_64) begin
        ticks_seen++;
        compare_next("tick");
      end
      if (probe_seq != mon_probes) begin
        mon_probes++;
        compare_next("probe");
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic probe(input string nm, input int v, input int a, input int d);
    expect_state(nm, v, a, d);
    probe_seq++;
    cyc(1);
  endtask

  task automatic pulse(input string nm, input int v, input int a, input int d, input int hi);
    expect_state(nm, v, a, d);
    pulses_sent++;
    bus.clock_64 = 1'b1;
    cyc(hi);
    bus.clock_64 = 1'b0;
    cyc(4);
  endtask

  task automatic trig(input int v, input int d, input int p);
    bus.init_volume = 4'(v);
    bus.env_dir     = 1'(d);
    bus.env_period  = 3'(p);
    bus.trigger     = 1'b1;
    cyc(1);
    bus.trigger     = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1);
  end

  initial begin
    int lat;
    bit found;
    bus.clock_64    = 1'b0;
    bus.trigger     = 1'b0;
    bus.init_volume = '0;
    bus.env_dir     = 1'b0;
    bus.env_period  = '0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    probe("reset", 0, 0, 0);

    // Tick latency from clock_64 rise, then a long high level yields one tick.
    expect_state("latency", 0, 0, 0);
    pulses_sent++;
    bus.clock_64 = 1'b1;
    lat = 0;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.tick_64) begin
        found = 1'b1;
        break;
      end
    end
    if (found) check("tick_latency", lat, EXP_LAT);
    else begin
      checks++;
      $display("FAIL tick_latency: no tick within 10 cycles, required %0d", EXP_LAT);
    end
    cyc(6);
    bus.clock_64 = 1'b0;
    cyc(4);
    pulse("idle", 0, 0, 0, 1);
    pulse("idle", 0, 0, 0, 2);

    trig(3, 1, 2);
    probe("ramp_load", 3, 1, 1);
    for (int n = 1; n <= 26; n++) begin
      int v;
      v = 3 + (n - 1) / 2;
      if (v > 15) v = 15;
      pulse("ramp", v, 1, 1, 1);
    end
    probe("ramp_end", 15, 0, 1);
    pulse("ramp_idle", 15, 0, 1, 1);

    trig(2, 0, 1);
    probe("down_load", 2, 1, 1);
    pulse("down", 2, 1, 1, 1);
    pulse("down", 1, 1, 1, 1);
    pulse("down", 0, 1, 1, 1);
    probe("down_end", 0, 0, 1);

    trig(9, 0, 0);
    probe("frozen_load", 9, 0, 1);
    pulse("frozen", 9, 0, 1, 1);
    pulse("frozen", 9, 0, 1, 1);
    trig(0, 0, 0);
    probe("dac_off", 0, 0, 0);

    trig(7, 1, 4);
    probe("coinc_load7", 7, 1, 1);
    expect_state("coinc_pre", 7, 1, 1);
    pulses_sent++;
    bus.clock_64 = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.tick_64) begin
        found = 1'b1;
        break;
      end
    end
    if (!found) begin
      checks++;
      $display("FAIL coinc_tick: no tick within 10 cycles, required a tick");
    end
    #1;
    bus.init_volume = 4'd10;
    bus.env_dir     = 1'b0;
    bus.env_period  = 3'd5;
    bus.trigger     = 1'b1;
    @(posedge clk);
    #1;
    bus.trigger = 1'b0;
    cyc(2);
    bus.clock_64 = 1'b0;
    cyc(4);
    probe("coinc_load10", 10, 1, 1);
    for (int n = 0; n < 5; n++) pulse("coinc_count", 10, 1, 1, 1);
    probe("coinc_step", 9, 1, 1);

    trig(12, 0, 3);
    pulse("rst_pre", 12, 1, 1, 1);
    rst_n = 1'b0;
    probe("async_rst", 0, 0, 1);
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
    probe("rst_after", 0, 0, 1);
    pulse("post_rst", 0, 0, 1, 1);

    cyc(5);
    check("queue_drained", exp_q.size(), 0);
    check("tick_count", ticks_seen, pulses_sent);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
